// File: rtl/wb_i2c_dac_sched.sv
// Round-robin scheduler sharing one I2C4BYTES DAC write engine between N_REQ requesters.
// Sequences ENABLE with setup/hold/gap timing and waits for engine completion or timeout.
//
// state | meaning
// IDLE  | waiting for any request; grants round-robin and latches payload
// SETUP | payload stable on engine inputs, enable low
// FIRE  | enable held high
// WAIT  | enable low, waiting for sticky engine done or timeout
// GAP   | enable low spacing; done/err pulse on the last cycle
module wb_i2c_dac_sched #(
  parameter int N_REQ       = 3,
  parameter int SETUP_CYC   = 4,
  parameter int ENABLE_CYC  = 8,
  parameter int TIMEOUT_CYC = 1000,
  parameter int GAP_CYC     = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [N_REQ-1:0]      req_i,
  input  logic [2*N_REQ-1:0]    lines_i,
  input  logic [16*N_REQ-1:0]   data12_i,
  input  logic [16*N_REQ-1:0]   data34_i,
  output logic [N_REQ-1:0]      gnt_o,
  output logic [N_REQ-1:0]      done_o,
  output logic                  err_o,
  output logic                  busy_o,
  output logic [1:0]            i2c_lines_o,
  output logic [15:0]           i2c_data12_o,
  output logic [15:0]           i2c_data34_o,
  output logic                  i2c_enable_o,
  input  logic                  i2c_done_i
);

  // Zero-valued timing parameters behave as one cycle
  localparam int SETUP_N   = (SETUP_CYC   < 1) ? 1 : SETUP_CYC;
  localparam int ENABLE_N  = (ENABLE_CYC  < 1) ? 1 : ENABLE_CYC;
  localparam int TIMEOUT_N = (TIMEOUT_CYC < 1) ? 1 : TIMEOUT_CYC;
  localparam int GAP_N     = (GAP_CYC     < 1) ? 1 : GAP_CYC;
  localparam int MAX_A     = (SETUP_N > ENABLE_N) ? SETUP_N : ENABLE_N;
  localparam int MAX_B     = (TIMEOUT_N > GAP_N) ? TIMEOUT_N : GAP_N;
  localparam int MAX_C     = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW        = $clog2(MAX_C) + 1;
  localparam int PW        = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [CW-1:0] SETUP_LD   = CW'(SETUP_N - 1);
  localparam logic [CW-1:0] ENABLE_LD  = CW'(ENABLE_N - 1);
  localparam logic [CW-1:0] TIMEOUT_LD = CW'(TIMEOUT_N - 1);
  localparam logic [CW-1:0] GAP_LD     = CW'(GAP_N - 1);

  typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_FIRE, ST_WAIT, ST_GAP} state_t;

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic [PW-1:0]      r_ptr;
  logic [PW-1:0]      r_sel;
  logic               r_sticky;
  logic               r_timeout;
  logic [N_REQ-1:0]   r_gnt;
  logic [N_REQ-1:0]   r_done;
  logic               r_err;
  logic               r_busy;
  logic [1:0]         r_lines;
  logic [15:0]        r_data12;
  logic [15:0]        r_data34;
  logic               r_enable;

  logic               w_found;
  logic [PW-1:0]      w_sel;

  // First set request after the pointer, wrapping modulo N_REQ
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!w_found && req_i[(int'(r_ptr) + k) % N_REQ]) begin
        w_found = 1'b1;
        w_sel   = PW'((int'(r_ptr) + k) % N_REQ);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_ptr     <= PW'(N_REQ - 1);
      r_sel     <= '0;
      r_sticky  <= 1'b0;
      r_timeout <= 1'b0;
      r_gnt     <= '0;
      r_done    <= '0;
      r_err     <= 1'b0;
      r_busy    <= 1'b0;
      r_lines   <= '0;
      r_data12  <= '0;
      r_data34  <= '0;
      r_enable  <= 1'b0;
    end else begin
      r_done <= '0;
      r_err  <= 1'b0;
      if ((r_state == ST_FIRE || r_state == ST_WAIT) && i2c_done_i)
        r_sticky <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_state  <= ST_SETUP;
            r_cnt    <= SETUP_LD;
            r_sel    <= w_sel;
            r_gnt    <= N_REQ'(1) << w_sel;
            r_busy   <= 1'b1;
            r_sticky <= 1'b0;
            r_lines  <= lines_i[2*int'(w_sel) +: 2];
            r_data12 <= data12_i[16*int'(w_sel) +: 16];
            r_data34 <= data34_i[16*int'(w_sel) +: 16];
          end
        end
        ST_SETUP: begin
          if (r_cnt == '0) begin
            r_state  <= ST_FIRE;
            r_cnt    <= ENABLE_LD;
            r_enable <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_FIRE: begin
          if (r_cnt == '0) begin
            r_state  <= ST_WAIT;
            r_cnt    <= TIMEOUT_LD;
            r_enable <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_WAIT: begin
          if (r_sticky || r_cnt == '0) begin
            r_state   <= ST_GAP;
            r_cnt     <= GAP_LD;
            r_timeout <= !r_sticky;
            // Single-cycle gap: the pulse lands in the first (and last) gap cycle
            if (GAP_LD == '0) begin
              r_done <= r_gnt;
              r_err  <= !r_sticky;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_GAP: begin
          if (r_cnt == '0) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_busy  <= 1'b0;
            r_ptr   <= r_sel;
          end else begin
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == CW'(1)) begin
              r_done <= r_gnt;
              r_err  <= r_timeout;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign gnt_o        = r_gnt;
  assign done_o       = r_done;
  assign err_o        = r_err;
  assign busy_o       = r_busy;
  assign i2c_lines_o  = r_lines;
  assign i2c_data12_o = r_data12;
  assign i2c_data34_o = r_data34;
  assign i2c_enable_o = r_enable;

endmodule
